seg7_scan_capture: RTL and testbench
====================================

// Module: seg7_scan_capture
// PURPOSE
//  Recovers hex values from a multiplexed, active-high 7-segment drive bus (seg a..g, dp, one-hot anodes).
//  Inverse of the board's hex->segment decoder: samples, qualifies, decodes and stores one nibble per digit.
//  Sits between the board's segment pins (or a display-driver under test) and the checker/host logic.
// PARAMETERS
//  NDIG        4     number of multiplexed digits (anode lines), 1..8
//  STABLE_CYC  16    consecutive identical synced samples required before a slot is committed (>=2)
//  TIMEOUT     2^20  cycles without any commit before 'stale' asserts; counter width = clog2(TIMEOUT+1)
// PORTS
//  clk         in   1        single system clock
//  rst_n       in   1        asynchronous active-low reset
//  seg_in      in   7        segments {a,b,c,d,e,f,g}, a = bit 6, active-high
//  dp_in       in   1        decimal point, active-high
//  an_in       in   NDIG     digit select, active-high, expected one-hot or all-zero
//  digits      out  4*NDIG   decoded nibble per digit, digit i at [4i+3:4i]
//  dp_out      out  NDIG     captured dp per digit
//  blank       out  NDIG     digit i last captured with seg_in == 7'h00
//  err         out  NDIG     digit i last captured with a pattern not in the hex table
//  upd_valid   out  1        one-cycle pulse: a slot was committed this cycle
//  upd_idx     out  3        index of the committed digit, valid with upd_valid
//  frame_done  out  1        one-cycle pulse: every digit committed at least once since the last pulse
//  stale       out  1        no commit for TIMEOUT cycles; clears on next commit
// BEHAVIOUR
//  Reset (async assert, sync release via synchronized rst_n): digits=0, dp_out=0, blank=all-1, err=0,
//   upd_valid=0, upd_idx=0, frame_done=0, stale=0, all counters/sync flops 0, FSM=IDLE.
//  Input sync: seg_in, dp_in, an_in pass two flop stages; all logic below uses synced copies (S).
//  FSM IDLE: S.an not one-hot -> stay; one-hot -> QUAL, stab_cnt=1, latch S as candidate.
//  FSM QUAL: S == candidate -> stab_cnt++; S differs -> if one-hot reload candidate, stab_cnt=1, else IDLE.
//   stab_cnt reaching STABLE_CYC -> COMMIT (no wrap; counter saturates).
//  FSM COMMIT (1 cycle): write digit idx=onehot2bin(candidate.an); update digits/dp_out/blank/err[idx];
//   upd_valid=1, upd_idx=idx -> HOLD.
//  FSM HOLD: wait while S.an unchanged (no re-commit of same slot); S.an changes -> IDLE same cycle logic.
//  Decode table {a..g}->nibble: 7E=0 30=1 6D=2 79=3 33=4 5B=5 5F=6 70=7 7F=8 73=9 77=A 1F=b 4E=C 3D=d 4F=E 47=F.
//   00 -> blank=1, err=0, nibble unchanged. Any other -> err=1, blank=0, nibble unchanged. Hit -> both 0.
//  Latency: first sync'd stable sample to upd_valid = STABLE_CYC cycles; pins to upd_valid = STABLE_CYC+2.
//  Frame tracking: seen[NDIG] set on commit; when all set, frame_done pulses the cycle after the commit
//   completing it and seen clears, but the completing bit is NOT carried over.
//  Same digit committed twice within a frame: allowed, only updates data; frame_done unaffected.
//  Multi-hot or all-zero anodes never commit; they abort QUAL (ghosting / blanking interval).
//  stale: idle counter increments every cycle, zero on commit, saturates; stale = (cnt >= TIMEOUT).
//  Reset asserted mid-QUAL or mid-COMMIT: immediate return to reset values; no partial write survives.
//  upd_idx width fixed at 3; upper bits 0 when NDIG<8.
// STRUCTURE
//  seg7_defs.vh: `define pattern constants (SEG_0..SEG_F, SEG_BLANK), FSM state encodings.
//  Sub-module seg7_pattern_decode (combinational): seg[6:0] -> {hit, blank, nibble[3:0]}.
//  Top holds sync flops, FSM, stability/idle counters, per-digit register array, frame tracking.
// TESTING
//  Reset: hold rst_n=0 with random inputs -> blank=all-1, digits=0, no upd_valid/frame_done.
//  Static scan NDIG=4, STABLE_CYC=16, 64 cyc/slot, digits 7E,30,6D,79 -> digits=16'h3210, 4 upd_valid, frame_done.
//  All 16 table entries + 00 + 7'h01 in slot 2 -> nibble 0..F, blank on 00, err on 01 with nibble held.
//  Glitch: change seg_in after 10 cycles in a slot -> no commit for old value; new value commits 16 cycles later.
//  Two-hot anode (4'b0011) for 100 cycles -> no upd_valid; restore one-hot -> normal commit.
//  Stop scanning, TIMEOUT=1000 -> stale=1 at cycle 1000; next commit clears stale; rst_n pulse mid-QUAL -> no commit.

Source files
------------

// File: rtl/seg7_scan_capture_pkg.sv
// Shared definitions for the 7-segment scan capture block.
// Holds the segment pattern constants ({a..g}, a = bit 6), the FSM state
// encoding, the decoder result payload and a one-hot to binary helper.
package seg7_scan_capture_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned IDX_W = 3;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h7E;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h33;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h5F;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h70;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h73;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h1F;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h4E;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h3D;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h47;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_QUAL   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    // Decoder result: hit = pattern found in the hex table.
    typedef struct packed {
        logic             hit;
        logic             blank;
        logic [NIB_W-1:0] nibble;
    } seg_dec_t;

    // Position of the set bit in a (one-hot) anode vector.
    function automatic logic [IDX_W-1:0] onehot2bin(input logic [7:0] oh);
        logic [IDX_W-1:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) b = IDX_W'(i);
        end
        return b;
    endfunction

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Pin-side and result-side signals of the scan capture block.
//   seg_in/dp_in/an_in : multiplexed display drive (master drives)
//   digits/dp_out/blank/err/upd_valid/upd_idx/frame_done/stale : capture results
interface seg7_scan_capture_if #(
    parameter int unsigned NDIG = 4
);
    logic [6:0]        seg_in;
    logic              dp_in;
    logic [NDIG-1:0]   an_in;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   dp_out;
    logic [NDIG-1:0]   blank;
    logic [NDIG-1:0]   err;
    logic              upd_valid;
    logic [2:0]        upd_idx;
    logic              frame_done;
    logic              stale;

    modport master (
        output seg_in, dp_in, an_in,
        input  digits, dp_out, blank, err, upd_valid, upd_idx, frame_done, stale
    );

    modport slave (
        input  seg_in, dp_in, an_in,
        output digits, dp_out, blank, err, upd_valid, upd_idx, frame_done, stale
    );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex->7-segment decoder.
//   seg   : {a..g} pattern, a = bit 6
//   dec_c : hit (table entry), blank (all segments off), nibble (valid on hit)
module seg7_pattern_decode
    import seg7_scan_capture_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output seg_dec_t         dec_c
);

    always_comb begin
        dec_c     = '0;
        dec_c.hit = 1'b1;
        case (seg)
            SEG_0:     dec_c.nibble = 4'h0;
            SEG_1:     dec_c.nibble = 4'h1;
            SEG_2:     dec_c.nibble = 4'h2;
            SEG_3:     dec_c.nibble = 4'h3;
            SEG_4:     dec_c.nibble = 4'h4;
            SEG_5:     dec_c.nibble = 4'h5;
            SEG_6:     dec_c.nibble = 4'h6;
            SEG_7:     dec_c.nibble = 4'h7;
            SEG_8:     dec_c.nibble = 4'h8;
            SEG_9:     dec_c.nibble = 4'h9;
            SEG_A:     dec_c.nibble = 4'hA;
            SEG_B:     dec_c.nibble = 4'hB;
            SEG_C:     dec_c.nibble = 4'hC;
            SEG_D:     dec_c.nibble = 4'hD;
            SEG_E:     dec_c.nibble = 4'hE;
            SEG_F:     dec_c.nibble = 4'hF;
            SEG_BLANK: begin
                dec_c.hit   = 1'b0;
                dec_c.blank = 1'b1;
            end
            default:   dec_c.hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Recovers hex digits from a multiplexed active-high 7-segment drive bus.
//   clk, rst_n : clock, asynchronous active-low reset (released synchronously)
//   bus        : slave side of seg7_scan_capture_if; pins in, per-digit
//                nibble/dp/blank/err plus update, frame and stale flags out
module seg7_scan_capture
    import seg7_scan_capture_pkg::*;
#(
    parameter int unsigned NDIG       = 4,
    parameter int unsigned STABLE_CYC = 16,
    parameter int unsigned TIMEOUT    = 32'd1048576
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_capture_if.slave bus
);

    localparam int unsigned CNT_W  = $clog2(STABLE_CYC + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    // Reset synchronizer: assert immediately, release two clocks later.
    logic rst_meta_q, rst_sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    logic rst_core_n;
    assign rst_core_n = rst_sync_q;

    // Two-stage input synchronizers; everything downstream uses the *_s2 copies.
    logic [SEG_W-1:0] seg_s1_q, seg_s2_q;
    logic             dp_s1_q, dp_s2_q;
    logic [NDIG-1:0]  an_s1_q, an_s2_q;
    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            seg_s1_q <= '0;
            seg_s2_q <= '0;
            dp_s1_q  <= 1'b0;
            dp_s2_q  <= 1'b0;
            an_s1_q  <= '0;
            an_s2_q  <= '0;
        end else begin
            seg_s1_q <= bus.seg_in;
            seg_s2_q <= seg_s1_q;
            dp_s1_q  <= bus.dp_in;
            dp_s2_q  <= dp_s1_q;
            an_s1_q  <= bus.an_in;
            an_s2_q  <= an_s1_q;
        end
    end

    state_e            state_q, state_d;
    logic [SEG_W-1:0]  cand_seg_q, cand_seg_d;
    logic              cand_dp_q, cand_dp_d;
    logic [NDIG-1:0]   cand_an_q, cand_an_d;
    logic [CNT_W-1:0]  stab_q, stab_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [4*NDIG-1:0] digits_q, digits_d;
    logic [NDIG-1:0]   dp_q, dp_d;
    logic [NDIG-1:0]   blank_q, blank_d;
    logic [NDIG-1:0]   err_q, err_d;
    logic [NDIG-1:0]   seen_q, seen_d;
    logic              upd_valid_q, upd_valid_d;
    logic [IDX_W-1:0]  upd_idx_q, upd_idx_d;
    logic              frame_done_q, frame_done_d;
    logic              stale_q, stale_d;
    logic              commit_c;
    logic              onehot_c;
    logic              same_c;
    seg_dec_t          dec_c;

    seg7_pattern_decode u_decode (
        .seg   (cand_seg_q),
        .dec_c (dec_c)
    );

    assign onehot_c = $onehot(an_s2_q);
    assign same_c   = (seg_s2_q == cand_seg_q) && (dp_s2_q == cand_dp_q) && (an_s2_q == cand_an_q);

    // Qualification FSM. The slot is written on the edge entering COMMIT so
    // that upd_valid and the new data appear together during COMMIT.
    always_comb begin
        state_d    = state_q;
        cand_seg_d = cand_seg_q;
        cand_dp_d  = cand_dp_q;
        cand_an_d  = cand_an_q;
        stab_d     = stab_q;
        commit_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (onehot_c) begin
                    state_d    = ST_QUAL;
                    cand_seg_d = seg_s2_q;
                    cand_dp_d  = dp_s2_q;
                    cand_an_d  = an_s2_q;
                    stab_d     = CNT_W'(1);
                end
            end
            ST_QUAL: begin
                if (same_c) begin
                    if (stab_q == CNT_W'(STABLE_CYC - 1)) begin
                        state_d  = ST_COMMIT;
                        stab_d   = CNT_W'(STABLE_CYC);
                        commit_c = 1'b1;
                    end else begin
                        stab_d = stab_q + CNT_W'(1);
                    end
                end else if (onehot_c) begin
                    cand_seg_d = seg_s2_q;
                    cand_dp_d  = dp_s2_q;
                    cand_an_d  = an_s2_q;
                    stab_d     = CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    stab_d  = '0;
                end
            end
            ST_COMMIT: begin
                state_d = ST_HOLD;
                stab_d  = '0;
            end
            ST_HOLD: begin
                // Leaving the slot behaves exactly like IDLE seeing this sample.
                if (an_s2_q != cand_an_q) begin
                    if (onehot_c) begin
                        state_d    = ST_QUAL;
                        cand_seg_d = seg_s2_q;
                        cand_dp_d  = dp_s2_q;
                        cand_an_d  = an_s2_q;
                        stab_d     = CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                stab_d  = '0;
            end
        endcase
    end

    // Per-digit register file, frame tracking and idle timer.
    always_comb begin
        digits_d    = digits_q;
        dp_d        = dp_q;
        blank_d     = blank_q;
        err_d       = err_q;
        upd_valid_d = commit_c;
        upd_idx_d   = upd_idx_q;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (commit_c && cand_an_q[i]) begin
                if (dec_c.hit) digits_d[4*i +: 4] = dec_c.nibble;
                dp_d[i]    = cand_dp_q;
                blank_d[i] = dec_c.blank;
                err_d[i]   = !dec_c.hit && !dec_c.blank;
            end
        end
        if (commit_c) upd_idx_d = onehot2bin(8'(cand_an_q));

        // A completed frame clears seen entirely; commits are never adjacent,
        // so no commit can coincide with the clearing cycle.
        frame_done_d = &seen_q;
        if (&seen_q)       seen_d = '0;
        else if (commit_c) seen_d = seen_q | cand_an_q;
        else               seen_d = seen_q;

        if (commit_c)                          idle_d = '0;
        else if (idle_q >= IDLE_W'(TIMEOUT))   idle_d = idle_q;
        else                                   idle_d = idle_q + IDLE_W'(1);
        stale_d = (idle_d >= IDLE_W'(TIMEOUT));
    end

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q      <= ST_IDLE;
            cand_seg_q   <= '0;
            cand_dp_q    <= 1'b0;
            cand_an_q    <= '0;
            stab_q       <= '0;
            idle_q       <= '0;
            digits_q     <= '0;
            dp_q         <= '0;
            blank_q      <= '1;
            err_q        <= '0;
            seen_q       <= '0;
            upd_valid_q  <= 1'b0;
            upd_idx_q    <= '0;
            frame_done_q <= 1'b0;
            stale_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_seg_q   <= cand_seg_d;
            cand_dp_q    <= cand_dp_d;
            cand_an_q    <= cand_an_d;
            stab_q       <= stab_d;
            idle_q       <= idle_d;
            digits_q     <= digits_d;
            dp_q         <= dp_d;
            blank_q      <= blank_d;
            err_q        <= err_d;
            seen_q       <= seen_d;
            upd_valid_q  <= upd_valid_d;
            upd_idx_q    <= upd_idx_d;
            frame_done_q <= frame_done_d;
            stale_q      <= stale_d;
        end
    end

    assign bus.digits     = digits_q;
    assign bus.dp_out     = dp_q;
    assign bus.blank      = blank_q;
    assign bus.err        = err_q;
    assign bus.upd_valid  = upd_valid_q;
    assign bus.upd_idx    = upd_idx_q;
    assign bus.frame_done = frame_done_q;
    assign bus.stale      = stale_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Testbench for seg7_scan_capture: directed scenarios plus random scanning,
// checked every cycle against a run-length model of the capture rules.
module tb_seg7_scan_capture;

    localparam int NDIG    = 4;
    localparam int STABLE  = 16;
    localparam int TIMEOUT = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_capture_if #(.NDIG(NDIG)) bus ();

    seg7_scan_capture #(
        .NDIG       (NDIG),
        .STABLE_CYC (STABLE),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [6:0] pat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int upd_cnt = 0;
    int fd_cnt  = 0;
    int last_upd_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [1:0] m_rs;
    logic [6:0] m_seg1, m_seg2;
    logic       m_dp1, m_dp2;
    logic [3:0] m_an1, m_an2;
    logic [3:0] e_nib [4];
    logic [3:0] e_dp, e_blank, e_err, seen, blk_an, r_an;
    logic       e_upd, e_fd, e_stale, r_dp, ign, blk;
    logic [2:0] e_idx;
    logic [6:0] r_seg;
    int         r_len, idle;

    task automatic m_reset();
        m_rs = 2'b00;
        m_seg1 = '0; m_seg2 = '0; m_dp1 = 0; m_dp2 = 0; m_an1 = '0; m_an2 = '0;
        for (int i = 0; i < 4; i++) e_nib[i] = 4'h0;
        e_dp = '0; e_blank = 4'hF; e_err = '0; e_upd = 0; e_idx = '0; e_fd = 0; e_stale = 0;
        seen = '0; r_len = 0; r_seg = '0; r_dp = 0; r_an = '0; ign = 0; blk = 0; blk_an = '0;
        idle = 0;
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reset();
        end else if (!m_rs[1]) begin
            m_rs = {m_rs[0], 1'b1};
        end else begin
            bit commit;
            commit = 0;
            e_upd  = 0;
            e_fd   = (seen == 4'hF);
            if (e_fd) seen = 4'h0;
            if (ign) begin
                ign = 0;                       // sample during the commit cycle is not looked at
            end else if (!(blk && m_an2 == blk_an)) begin
                blk = 0;
                if (r_len > 0 && m_seg2 == r_seg && m_dp2 == r_dp && m_an2 == r_an)
                    r_len++;
                else if ($countones(m_an2) == 1) begin
                    r_seg = m_seg2; r_dp = m_dp2; r_an = m_an2; r_len = 1;
                end else
                    r_len = 0;
                if (r_len == STABLE) commit = 1;
            end
            if (commit) begin
                int  idx;
                bit  hit;
                logic [3:0] nib;
                idx = 0; hit = 0; nib = 0;
                for (int i = 0; i < 4; i++) if (r_an[i]) idx = i;
                for (int k = 0; k < 16; k++) if (pat[k] == r_seg) begin hit = 1; nib = 4'(k); end
                if (hit)                 begin e_nib[idx] = nib; e_blank[idx] = 0; e_err[idx] = 0; end
                else if (r_seg == 7'h00) begin e_blank[idx] = 1; e_err[idx] = 0; end
                else                     begin e_blank[idx] = 0; e_err[idx] = 1; end
                e_dp[idx] = r_dp;
                e_upd = 1; e_idx = 3'(idx); seen[idx] = 1'b1;
                r_len = 0; ign = 1; blk = 1; blk_an = r_an; idle = 0;
            end else if (idle < TIMEOUT) begin
                idle++;
            end
            e_stale = (idle >= TIMEOUT);
            m_seg2 = m_seg1; m_dp2 = m_dp1; m_an2 = m_an1;
            m_seg1 = bus.seg_in; m_dp1 = bus.dp_in; m_an1 = bus.an_in;
        end
    end

    function automatic logic [15:0] e_digits();
        logic [15:0] d;
        for (int i = 0; i < 4; i++) d[4*i +: 4] = e_nib[i];
        return d;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("digits",     32'(bus.digits),     32'(e_digits()));
        chk("dp_out",     32'(bus.dp_out),     32'(e_dp));
        chk("blank",      32'(bus.blank),      32'(e_blank));
        chk("err",        32'(bus.err),        32'(e_err));
        chk("upd_valid",  32'(bus.upd_valid),  32'(e_upd));
        chk("upd_idx",    32'(bus.upd_idx),    32'(e_idx));
        chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
        chk("stale",      32'(bus.stale),      32'(e_stale));
        if (bus.upd_valid === 1'b1) begin upd_cnt++; last_upd_cyc = cyc; end
        if (bus.frame_done === 1'b1) fd_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] s, input logic d, input logic [3:0] a);
        bus.seg_in = s;
        bus.dp_in  = d;
        bus.an_in  = a;
    endtask

    initial begin
        int u0, f0, start, sc;
        bit found;
        logic [6:0] p;
        drive(7'h00, 1'b0, 4'h0);

        // Reset held with random pin activity.
        for (int i = 0; i < 12; i++) begin
            tick(1);
            drive(7'($urandom), 1'($urandom), 4'($urandom));
        end
        chk("rst_blank",  32'(bus.blank),     32'hF);
        chk("rst_digits", 32'(bus.digits),    32'h0);
        chk("rst_upd",    32'(upd_cnt),       32'd0);
        chk("rst_fd",     32'(fd_cnt),        32'd0);
        drive(7'h00, 1'b0, 4'h0);
        tick(1);
        rst_n = 1'b1;
        tick(6);

        // Static scan of 0,1,2,3.
        u0 = upd_cnt; f0 = fd_cnt; start = 0;
        for (int i = 0; i < 4; i++) begin
            drive(pat[i], 1'b0, 4'(1 << i));
            start = cyc;
            tick(64);
            if (i == 0) chk("latency_pins_to_upd", 32'(last_upd_cyc - start), 32'd18);
        end
        drive(7'h00, 1'b0, 4'h0);
        tick(4);
        chk("scan_digits",   32'(bus.digits),     32'h3210);
        chk("model_scan",    32'(e_digits()),     32'h3210);
        chk("scan_upd_cnt",  32'(upd_cnt - u0),   32'd4);
        chk("scan_fd_cnt",   32'(fd_cnt - f0),    32'd1);
        chk("scan_blank",    32'(bus.blank),      32'h0);

        // Whole table plus blank and an invalid pattern, in slot 2.
        for (int k = 0; k < 18; k++) begin
            p = (k < 16) ? pat[k] : ((k == 16) ? 7'h00 : 7'h01);
            drive(7'h00, 1'b0, 4'h0);
            tick(4);
            drive(p, 1'(k), 4'b0100);
            tick(40);
            chk("table_nibble", 32'(bus.digits[11:8]), 32'((k < 16) ? k : 15));
            chk("table_blank",  32'(bus.blank[2]),     32'(k == 16));
            chk("table_err",    32'(bus.err[2]),       32'(k == 17));
            chk("table_dp",     32'(bus.dp_out[2]),    32'(k % 2));
        end

        // Glitch: 5 shown for 10 cycles then 9.
        drive(7'h00, 1'b0, 4'h0);
        tick(4);
        u0 = upd_cnt;
        drive(7'h5B, 1'b0, 4'b0010);
        tick(10);
        drive(7'h73, 1'b0, 4'b0010);
        start = cyc;
        tick(40);
        chk("glitch_upd_cnt", 32'(upd_cnt - u0),         32'd1);
        chk("glitch_latency", 32'(last_upd_cyc - start), 32'd18);
        chk("glitch_digit",   32'(bus.digits[7:4]),      32'h9);
        chk("model_glitch",   32'(e_nib[1]),             32'h9);

        // Two-hot anodes never commit.
        drive(7'h00, 1'b0, 4'h0);
        tick(4);
        u0 = upd_cnt;
        drive(7'h7F, 1'b0, 4'b0011);
        tick(100);
        chk("twohot_no_upd", 32'(upd_cnt - u0), 32'd0);
        drive(7'h7F, 1'b0, 4'b0001);
        tick(40);
        chk("twohot_restore_upd", 32'(upd_cnt - u0),     32'd1);
        chk("twohot_digit",       32'(bus.digits[3:0]),  32'h8);

        // Scanning stops: stale after TIMEOUT idle cycles.
        drive(7'h00, 1'b0, 4'h0);
        found = 0; sc = 0;
        for (int n = 0; n < 1100 && !found; n++) begin
            tick(1);
            if (bus.stale === 1'b1) begin found = 1; sc = cyc; end
        end
        chk("stale_found", 32'(found), 32'd1);
        if (found) chk("stale_delay", 32'(sc - last_upd_cyc), 32'd1000);
        u0 = upd_cnt;
        drive(7'h4F, 1'b1, 4'b0100);
        tick(40);
        chk("stale_clear",     32'(bus.stale),     32'd0);
        chk("stale_clear_upd", 32'(upd_cnt - u0),  32'd1);

        // Reset pulse while qualifying a slot.
        drive(7'h00, 1'b0, 4'h0);
        tick(4);
        u0 = upd_cnt;
        drive(7'h77, 1'b0, 4'b1000);
        tick(8);
        rst_n = 1'b0;
        drive(7'h00, 1'b0, 4'h0);
        tick(3);
        chk("midqual_rst_digits", 32'(bus.digits), 32'h0);
        chk("midqual_rst_blank",  32'(bus.blank),  32'hF);
        rst_n = 1'b1;
        tick(40);
        chk("midqual_no_upd",  32'(upd_cnt - u0), 32'd0);
        chk("midqual_digits",  32'(bus.digits),   32'h0);

        // Random scanning with glitches, blanking and ghosting.
        for (int s = 0; s < 600; s++) begin
            int r1, r2;
            logic [3:0] a;
            r1 = $urandom_range(0, 9);
            r2 = $urandom_range(0, 9);
            if (r1 < 6)      a = 4'(1 << $urandom_range(0, 3));
            else if (r1 < 8) a = 4'h0;
            else             a = 4'($urandom);
            if (r2 < 7)       p = pat[$urandom_range(0, 15)];
            else if (r2 == 7) p = 7'h00;
            else              p = 7'($urandom);
            drive(p, 1'($urandom), a);
            tick($urandom_range(1, 40));
        end
        drive(7'h00, 1'b0, 4'h0);
        tick(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
